scope_trigger_capture: RTL

- Writer side of the oscilloscope sample buffer: samples the 16-bit input on CLOCK_50 (decimated) into a 64-entry circular RAM.
- Detects a level/edge trigger and freezes a frame holding PRETRIG samples before the trigger and the remainder after it.
- Hands the frame to the VGA display reader via a ready/ack handshake; the reader addresses the frame trigger-relative.

---
 rtl/scope_trigger_capture.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/scope_trigger_capture.sv
// scope_trigger_capture: writer side of the oscilloscope sample buffer.
//   Samples 'signal' (decimated by DECIM) into a DEPTH-entry circular RAM, waits for a
//   rising/falling crossing of trig_level (or an auto timeout), then freezes a frame of
//   PRETRIG samples before the trigger and DEPTH-PRETRIG-1 after it.
// Ports:
//   CLOCK_50, reset (async, active-high)       - clock / reset
//   signal, trig_level, trig_falling           - sample input and trigger setup
//   continuous, arm, frame_ack                 - capture control and reader handshake
//   rd_addr -> rd_data (1-cycle latency)       - trigger-relative frame read port
//   frame_ready, trig_forced, state            - status
module scope_trigger_capture #(
    parameter int DW      = 16,
    parameter int AW      = 6,
    parameter int PRETRIG = 8,
    parameter int DECIM   = 1,
    parameter int AUTO_TO = 1024
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic [DW-1:0] signal,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_falling,
    input  logic          continuous,
    input  logic          arm,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          frame_ready,
    output logic          trig_forced,
    output logic [2:0]    state
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW    = $clog2(AUTO_TO + 2);

    localparam logic [AW-1:0] PRE_N    = AW'(PRETRIG);
    localparam logic [AW-1:0] POST_N   = AW'(DEPTH - PRETRIG - 1);
    localparam logic [CW-1:0] DEC_LAST = CW'(DECIM - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'((AUTO_TO > 0) ? AUTO_TO - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] decim_q, decim_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] start_ptr_q, start_ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;            // PRE: samples written; POST: samples remaining
    logic [TW-1:0] to_q, to_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          prev_valid_q, prev_valid_d;
    logic          frame_ready_q, frame_ready_d;
    logic          trig_forced_q, trig_forced_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic [DW-1:0] mem [DEPTH];

    logic sampling, strobe, real_hit, to_hit, go_pre;

    always_comb begin
        state_d       = state_q;
        decim_d       = decim_q;
        wr_ptr_d      = wr_ptr_q;
        start_ptr_d   = start_ptr_q;
        cnt_d         = cnt_q;
        to_d          = to_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        trig_forced_d = trig_forced_q;
        go_pre        = 1'b0;

        sampling = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
        strobe   = sampling && (decim_q == '0);

        if (sampling) begin
            decim_d = (decim_q == DEC_LAST) ? '0 : decim_q + 1'b1;
        end
        if (strobe) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        // Crossing is judged between the previously written sample and the current one.
        if (trig_falling) begin
            real_hit = prev_valid_q && (prev_q >= trig_level) && (signal < trig_level);
        end else begin
            real_hit = prev_valid_q && (prev_q < trig_level) && (signal >= trig_level);
        end
        to_hit = (AUTO_TO != 0) && (to_q == TO_LAST);

        case (state_q)
            S_IDLE: begin
                if (arm) go_pre = 1'b1;
            end
            S_PRE: begin
                if (strobe) begin
                    prev_d       = signal;
                    prev_valid_d = 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == PRE_N - 1'b1) state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (strobe) begin
                    prev_d       = signal;
                    prev_valid_d = 1'b1;
                    to_d         = to_q + 1'b1;
                    if (real_hit || to_hit) begin
                        trig_forced_d = !real_hit;
                        start_ptr_d   = wr_ptr_q - PRE_N;
                        cnt_d         = POST_N;
                        state_d       = (POST_N == '0) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST: begin
                if (strobe) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == AW'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (frame_ack) begin
                    if (continuous) go_pre  = 1'b1;
                    else            state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Fresh acquisition: a zero-length pre-trigger window skips PRE entirely.
        if (go_pre) begin
            state_d      = (PRETRIG == 0) ? S_ARMED : S_PRE;
            decim_d      = '0;
            wr_ptr_d     = '0;
            cnt_d        = '0;
            to_d         = '0;
            prev_valid_d = 1'b0;
        end

        // Status lags the state by one clock, so frame_ready drops the cycle after ack.
        frame_ready_d = (state_q == S_DONE);
        rd_data_d     = mem[start_ptr_q + rd_addr];
    end

    always_ff @(posedge CLOCK_50) begin
        if (strobe) mem[wr_ptr_q] <= signal;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            decim_q       <= '0;
            wr_ptr_q      <= '0;
            start_ptr_q   <= '0;
            cnt_q         <= '0;
            to_q          <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            trig_forced_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            decim_q       <= decim_d;
            wr_ptr_q      <= wr_ptr_d;
            start_ptr_q   <= start_ptr_d;
            cnt_q         <= cnt_d;
            to_q          <= to_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            frame_ready_q <= frame_ready_d;
            trig_forced_q <= trig_forced_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_ready = frame_ready_q;
    assign trig_forced = trig_forced_q;
    assign state       = state_q;

endmodule
